// File: rtl/csd2bin_seq.sv
// Sequential CSD-to-binary converter: shifts P digits per cycle into a two's-complement accumulator.
// Optional macro CSD2BIN_SEQ_NONCANON_CHECK_EN enables the adjacent-nonzero-digit (non-canonical) check.
module csd2bin_seq #(
    parameter int W     = 8,
    parameter int P     = 1,
    parameter int LOG2W = 3
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   csd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     bin_out,
    output logic             err_invalid,
    output logic             err_noncanon,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LOG2W:0] LAST_STEP = (LOG2W+1)'(W/P - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2*W-1:0]   sreg;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_nxt;
    logic [LOG2W:0]   cnt;
    logic             inv_flag;
    logic             inv_nxt;
    logic             accept;
    logic             last_step;

    assign accept    = in_valid & in_ready;
    assign last_step = (cnt == LAST_STEP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (arst) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = enable;
                if (in_valid) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = enable & out_ready;
                if (out_ready) begin
                    state_nxt = in_valid ? CONV : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Digit j of this step carries weight 2^(cnt*P + j); code 11 contributes nothing.
    always_comb begin
        acc_nxt = acc;
        inv_nxt = inv_flag;
        for (int j = 0; j < P; j++) begin
            case (sreg[2*j +: 2])
                2'b01:   acc_nxt = acc_nxt + (W'(1) << (int'(cnt) * P + j));
                2'b10:   acc_nxt = acc_nxt - (W'(1) << (int'(cnt) * P + j));
                2'b11:   inv_nxt = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CSD2BIN_SEQ_NONCANON_CHECK_EN
    logic nc_flag;
    logic nc_nxt;
    logic prev_nz;
    logic prev_nz_nxt;

    // prev_nz carries the last digit of one step into the first digit of the next.
    always_comb begin
        nc_nxt      = nc_flag;
        prev_nz_nxt = prev_nz;
        for (int j = 0; j < P; j++) begin
            if (prev_nz_nxt && (sreg[2*j] ^ sreg[2*j+1])) begin
                nc_nxt = 1'b1;
            end
            prev_nz_nxt = sreg[2*j] ^ sreg[2*j+1];
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            nc_flag <= 1'b0;
            prev_nz <= 1'b0;
        end else if (enable) begin
            if (accept) begin
                nc_flag <= 1'b0;
                prev_nz <= 1'b0;
            end else if (state == CONV) begin
                nc_flag <= nc_nxt;
                prev_nz <= prev_nz_nxt;
            end
        end
    end

    assign err_noncanon = out_valid & nc_flag;
`else
    assign err_noncanon = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (arst) begin
            sreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            inv_flag <= 1'b0;
        end else if (enable) begin
            if (accept) begin
                sreg     <= csd_in;
                acc      <= '0;
                cnt      <= '0;
                inv_flag <= 1'b0;
            end else if (state == CONV) begin
                sreg     <= sreg >> (2*P);
                acc      <= acc_nxt;
                cnt      <= cnt + 1'b1;
                inv_flag <= inv_nxt;
            end
        end
    end

    assign bin_out     = out_valid ? acc : '0;
    assign err_invalid = out_valid & inv_flag;

endmodule

// File: tb/tb_csd2bin_seq.sv
// Scoreboard bench for csd2bin_seq: directed CSD words plus randomized traffic with enable/out_ready stalls.
module tb_csd2bin_seq;

    localparam int W     = 8;
    localparam int P     = 1;
    localparam int LOG2W = 3;

    logic           clk = 1'b0;
    logic           arst = 1'b1;
    logic           enable = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] csd_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   bin_out;
    logic           err_invalid;
    logic           err_noncanon;
    logic           busy;

    csd2bin_seq #(.W(W), .P(P), .LOG2W(LOG2W)) dut (
        .clk         (clk),
        .arst        (arst),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .csd_in      (csd_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bin_out     (bin_out),
        .err_invalid (err_invalid),
        .err_noncanon(err_noncanon),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] val;
        logic         inv;
        logic         nc;
        int           start;
    } exp_t;

    exp_t sb[$];
    bit   front_seen = 1'b0;
    int   en_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rand_active = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: sum of digit * 2^i taken modulo 2^W.
    function automatic logic [W-1:0] refValue(input logic [2*W-1:0] c);
        int v;
        int d;
        v = 0;
        for (int i = 0; i < W; i++) begin
            d = int'((c >> (2*i)) & 2'b11);
            if (d == 1) v = v + (1 << i);
            else if (d == 2) v = v - (1 << i);
        end
        return v[W-1:0];
    endfunction

    function automatic logic refInvalid(input logic [2*W-1:0] c);
        for (int i = 0; i < W; i++) begin
            if (((c >> (2*i)) & 2'b11) == 3) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic refNoncanon(input logic [2*W-1:0] c);
        int a;
        int b;
        for (int i = 0; i < W-1; i++) begin
            a = int'((c >> (2*i)) & 2'b11);
            b = int'((c >> (2*i+2)) & 2'b11);
            if ((a == 1 || a == 2) && (b == 1 || b == 2)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Monitor: compares what the DUT shows now, then records the handshakes of the coming edge.
    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        if (sb.size() == 0) begin
            checkOutput("idle_out_valid", out_valid, 0);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_bin_out", bin_out, 0);
            checkOutput("idle_in_ready", in_ready, enable);
        end else if (!out_valid) begin
            checkOutput("conv_busy", busy, 1);
            checkOutput("conv_bin_zero", bin_out, 0);
            checkOutput("conv_inv_zero", err_invalid, 0);
            checkOutput("conv_nc_zero", err_noncanon, 0);
            checkOutput("conv_in_ready", in_ready, 0);
        end else begin
            e = sb[0];
            checkOutput("bin_out", bin_out, e.val);
            checkOutput("err_invalid", err_invalid, e.inv);
            checkOutput("err_noncanon", err_noncanon, e.nc);
            checkOutput("done_in_ready", in_ready, enable & out_ready);
            if (!front_seen) begin
                checkOutput("latency_enabled_edges", en_cnt - e.start, W/P);
                front_seen = 1'b1;
            end
        end
        if (!enable) checkOutput("disabled_in_ready", in_ready, 0);

        if (arst) begin
            sb.delete();
            front_seen = 1'b0;
        end else if (enable) begin
            en_cnt++;
            if (out_valid && out_ready && sb.size() > 0) begin
                void'(sb.pop_front());
                front_seen = 1'b0;
            end
            if (in_valid && in_ready) begin
                n.val = refValue(csd_in);
                n.inv = refInvalid(csd_in);
`ifdef CSD2BIN_SEQ_NONCANON_CHECK_EN
                n.nc = refNoncanon(csd_in);
`else
                n.nc = 1'b0;
`endif
                n.start = en_cnt;
                sb.push_back(n);
            end
        end
    end

    task automatic applyStimulus(input logic [2*W-1:0] w);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        csd_in   = w;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("[TB] FAIL accept_timeout word=%0h", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        csd_in   = 16'($urandom);
    endtask

    task automatic runTimed(input string name, input logic [2*W-1:0] w, input bit stall, input int exp_n);
        int n;
        n = 0;
        applyStimulus(w);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (stall && n == 2) enable = 1'b0;
            if (stall && n == 5) enable = 1'b1;
            if (out_valid) break;
        end
        enable = 1'b1;
        checkOutput(name, n, exp_n);
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) return;
        end
        errors++;
        $display("[TB] FAIL drain_timeout pending=%0d", sb.size());
    endtask

    function automatic logic [2*W-1:0] randomWord();
        logic [2*W-1:0] w;
        int r;
        w = '0;
        for (int i = 0; i < W; i++) begin
            r = $urandom_range(0, 9);
            w[2*i +: 2] = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        end
        return w;
    endfunction

    initial begin
        arst = 1'b1;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);

        runTimed("latency_0042", 16'h0042, 1'b0, 8);
        applyStimulus(16'h0002);
        applyStimulus(16'h4000);
        applyStimulus(16'h0003);
        applyStimulus(16'h0005);
        waitDrain();

        // Consumer stalls 5 cycles, then takes the result while a new word arrives.
        out_ready = 1'b0;
        runTimed("hold_latency", 16'h1842, 1'b0, 8);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("hold_in_ready", in_ready, 0);
        out_ready = 1'b1;
        runTimed("b2b_latency", 16'h0090, 1'b0, 8);
        waitDrain();

        // Reset mid-conversion discards the word.
        applyStimulus(16'h0244);
        repeat (3) @(posedge clk);
        #1 arst = 1'b1;
        @(posedge clk);
        #1 arst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort_no_result", out_valid, 0);

        runTimed("stall_latency", 16'h2481, 1'b1, 11);
        waitDrain();

        rand_active = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) applyStimulus(randomWord());
                rand_active = 1'b0;
            end
            begin
                while (rand_active) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    enable    = ($urandom_range(0, 7) != 0);
                end
                out_ready = 1'b1;
                enable    = 1'b1;
            end
        join
        waitDrain();
        checkOutput("final_queue_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule

// File: doc/csd2bin_seq.md
CSD2BIN_SEQ -- requirements
Module: csd2bin_seq

Interface
REQ-001 SHALL have parameter W, default 8: binary result width and number of CSD digits.
REQ-002 SHALL have parameter P, default 1: digits decoded per cycle; legal values 1, 2, 4; W divisible by P.
REQ-003 SHALL have parameter LOG2W, default 3: ceil(log2(W)), sizing the digit counter as LOG2W+1 bits.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port arst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port enable, input, 1; low freezes all state.
REQ-007 SHALL have port in_valid, input, 1: csd_in is valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts csd_in.
REQ-009 SHALL have port csd_in, input, 2W: digit i is bits [2i+1:2i], with 00=0, 01=+1, 10=-1, 11=invalid.
REQ-010 SHALL have port out_valid, output, 1: result is valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port bin_out, output, W: two's-complement result.
REQ-013 SHALL have port err_invalid, output, 1: the word contained digit code 11.
REQ-014 SHALL have port err_noncanon, output, 1: the word contained two adjacent nonzero digits.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-016 SHALL implement an FSM with three states:
- IDLE: in_ready = enable.
- CONV: in_ready = 0.
- DONE: out_valid = 1; in_ready = enable & out_ready.
REQ-017 SHALL, on an accept (in_valid & in_ready at an enabled edge), load csd_in into the shift register, clear the accumulator, error flags and counter, and enter CONV.
REQ-018 SHALL, on each enabled CONV edge, process the P lowest unprocessed digits LSB-first: acc += 2^i for +1, acc -= 2^i for -1, add 0 for invalid; arithmetic is modulo 2^W.
REQ-019 SHALL leave CONV for DONE on the edge that processes digit W-1.
- An accept at edge t0 gives out_valid high after edge t0+W/P (8 cycles for W=8, P=1).
REQ-020 SHALL hold bin_out, err_invalid and err_noncanon stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, in DONE with out_ready=1:
- with in_valid=1: perform the handshake and accept the next word on the same edge (back-to-back, no IDLE bubble);
- otherwise: return to IDLE.
REQ-022 SHALL set err_invalid if any digit equals 11.
REQ-023 SHALL, while enable=0, hold state, counter, accumulator and outputs, and drive in_ready=0; out_valid SHALL keep its value.
REQ-024 SHALL drive bin_out, err_invalid and err_noncanon to 0 whenever out_valid=0.
REQ-025 SHALL ignore csd_in and in_valid when in_ready=0.

Reset
REQ-026 SHALL, on arst=1 at a clock edge, regardless of enable, enter IDLE and clear the accumulator, counter, shift register and error flags.
- Reset values: out_valid=0, bin_out=0, err_invalid=0, err_noncanon=0, busy=0; in_ready=enable.
REQ-027 SHALL abort a conversion in progress on reset, producing no result for that word.

Configuration
REQ-028 SHALL provide macro CSD2BIN_SEQ_NONCANON_CHECK_EN.
- Defined: err_noncanon is set when adjacent digits i and i+1 are both nonzero (01 or 10), including across P-digit cycle boundaries; a 1-bit "previous digit nonzero" register is kept for the cross-boundary case.
- Undefined: err_noncanon is tied to 0, and the register and check logic SHALL be absent.

Verification
REQ-029 SHALL cover the following directed scenarios (W=8, P=1):
- csd_in=0x0042 (+8-1) -> out_valid after 8 cycles, bin_out=0x07, both error flags 0.
- csd_in=0x0002 (-1) -> bin_out=0xFF; csd_in=0x4000 (+2^7) -> bin_out=0x80 (wrap).
- csd_in=0x0003 -> bin_out=0x00, err_invalid=1.
- csd_in=0x0005 (+2+1) -> bin_out=0x03; err_noncanon=1 with the macro, 0 without.
- out_ready held 0 for 5 cycles after out_valid -> bin_out stable, in_ready=0; then out_ready=1 with in_valid=1 -> next word accepted on that edge, next result 8 cycles later.
- arst at the 4th CONV cycle -> IDLE next cycle, out_valid never asserted for that word; enable=0 for 3 cycles mid-CONV -> result delayed by 3 cycles and correct.
